// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / PC stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned R15_OFFSET = 8;

  typedef logic [31:0] addr_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Event counters for the fetch stage; instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        handshake,
  input  logic        stall,
  input  logic        redirect,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] redirect_count
);

  // All counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count    <= '0;
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (handshake) fetch_count    <= fetch_count + 32'd1;
      if (stall)     stall_count    <= stall_count + 32'd1;
      if (redirect)  redirect_count <= redirect_count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC ownership, instruction fetch and decode hand-off with R15 (= pc + 8) generation.
// Optional performance counters are built in when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  r15,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
  output logic [31:0]        redirect_count
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] OFFS = ADDR_W'(R15_OFFSET);

  // Handshakes: a fetch completes in a cycle with imem_req && imem_ready; imem_req and
  // imem_addr stay stable until then. Decode consumes instr in a cycle with
  // instr_valid && dec_ready. A redirect overrides both in the cycle it is seen.
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_tgt_lo;

  assign redir_pc      = {redirect_target[ADDR_W-1:2], 2'b00};
  assign pc_inc        = pc + STEP;
  assign unused_tgt_lo = ^redirect_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= F_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      r15         <= RESET_PC + OFFS;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over fetch completion (rdata dropped) and over pc+4.
      state       <= F_REQ;
      pc          <= redir_pc;
      imem_req    <= 1'b1;
      imem_addr   <= redir_pc;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          state     <= F_REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        F_REQ: begin
          if (imem_ready) begin
            state       <= F_HOLD;
            imem_req    <= 1'b0;
            instr       <= imem_rdata;
            instr_pc    <= pc;
            r15         <= pc + OFFS;
            instr_valid <= 1'b1;
          end
        end
        F_HOLD: begin
          if (dec_ready) begin
            state       <= F_REQ;
            pc          <= pc_inc;
            imem_req    <= 1'b1;
            imem_addr   <= pc_inc;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state    <= F_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic perf_hs;
  logic perf_stall;

  assign perf_hs    = (state == F_HOLD) && dec_ready;
  assign perf_stall = ((state == F_HOLD) && !dec_ready) || ((state == F_REQ) && !imem_ready);

  fetch_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .handshake      (perf_hs),
    .stall          (perf_stall),
    .redirect       (redirect_valid),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
  );
`endif

endmodule
